udp_tx_frame_buffer: RTL and testbench

- Store-and-forward byte buffer that drives packet_tx's slave AXI-Stream port.
- Accepts an unframed-length payload from user logic and counts its bytes.
- Once tlast arrives, replays the whole payload with the 12-bit byte count held constant on tuser, which packet_tx needs up front for its IP/UDP length fields.
- Payloads that exceed MAX_LEN are discarded whole and flagged.

---
 rtl/eth_pkg.sv | 15 +
 rtl/frame_ram.sv | 30 +++
 rtl/udp_tx_frame_buffer.sv | 168 ++++++++++++++++
 tb/tb_udp_tx_frame_buffer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet/UDP constants and the frame-buffer state encoding.
package eth_pkg;

    localparam int unsigned ETH_LEN_W       = 12;
    localparam int unsigned UDP_MAX_PAYLOAD = 1472;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_DROP,
        ST_PRIME,
        ST_DRAIN
    } state_e;

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port byte RAM: synchronous write, registered read with enable.
module frame_ram #(
    parameter int unsigned DEPTH = 2048,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    // Read register only updates when enabled, so it holds during output stalls.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/udp_tx_frame_buffer.sv
// Store-and-forward payload buffer: counts a user frame, then replays it with
// its byte length held on tuser for packet_tx; oversize frames are dropped.
module udp_tx_frame_buffer
    import eth_pkg::*;
#(
    parameter int unsigned DEPTH   = 2048,
    parameter int unsigned MAX_LEN = UDP_MAX_PAYLOAD,
    parameter int unsigned LEN_W   = ETH_LEN_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [7:0]       s_axis_tdata_i,
    input  logic             s_axis_tvalid_i,
    input  logic             s_axis_tlast_i,
    output logic             s_axis_tready_o,
    output logic [7:0]       m_axis_tdata_o,
    output logic             m_axis_tvalid_o,
    output logic             m_axis_tlast_o,
    output logic [LEN_W-1:0] m_axis_tuser_o,
    input  logic             m_axis_tready_i,
    output logic             drop_o,
    output logic             busy_o
);

    localparam int unsigned     AW        = $clog2(DEPTH);
    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] out_idx_q, out_idx_d;
    logic [LEN_W-1:0] tuser_q, tuser_d;
    logic             tvalid_q, tvalid_d;
    logic             drop_q, drop_d;

    logic             s_ready, s_fire, m_fire, out_last;
    logic [LEN_W-1:0] next_idx;
    logic             ram_we, ram_re;
    logic [AW-1:0]    ram_raddr;
    logic [7:0]       ram_rdata;

    frame_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .waddr_i (wr_cnt_q[AW-1:0]),
        .wdata_i (s_axis_tdata_i),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    assign s_ready  = (state_q == ST_IDLE) || (state_q == ST_FILL) || (state_q == ST_DROP);
    assign s_fire   = s_axis_tvalid_i && s_ready;
    assign m_fire   = tvalid_q && m_axis_tready_i;
    assign next_idx = out_idx_q + LEN_W'(1);
    assign out_last = (out_idx_q == len_q - LEN_W'(1));

    always_comb begin
        state_d   = state_q;
        wr_cnt_d  = wr_cnt_q;
        len_d     = len_q;
        out_idx_d = out_idx_q;
        tvalid_d  = tvalid_q;
        tuser_d   = tuser_q;
        drop_d    = 1'b0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_raddr = next_idx[AW-1:0];

        unique case (state_q)
            ST_IDLE: begin
                if (s_fire) begin
                    ram_we   = 1'b1;
                    wr_cnt_d = LEN_W'(1);
                    if (s_axis_tlast_i) begin
                        len_d   = LEN_W'(1);
                        state_d = ST_PRIME;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                if (s_fire) begin
                    if (wr_cnt_q == MAX_LEN_C) begin
                        // Oversize: a tlast on this very byte ends the discard at once.
                        wr_cnt_d = '0;
                        if (s_axis_tlast_i) begin
                            drop_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_DROP;
                        end
                    end else begin
                        ram_we   = 1'b1;
                        wr_cnt_d = wr_cnt_q + LEN_W'(1);
                        if (s_axis_tlast_i) begin
                            len_d   = wr_cnt_q + LEN_W'(1);
                            state_d = ST_PRIME;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (s_fire && s_axis_tlast_i) begin
                    drop_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_PRIME: begin
                ram_re    = 1'b1;
                ram_raddr = '0;
                out_idx_d = '0;
                tvalid_d  = 1'b1;
                tuser_d   = len_q;
                wr_cnt_d  = '0;
                state_d   = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Next byte is fetched on the accepting edge, keeping 1 byte/cycle.
                if (m_fire) begin
                    if (out_last) begin
                        tvalid_d = 1'b0;
                        tuser_d  = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        ram_re    = 1'b1;
                        out_idx_d = next_idx;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            wr_cnt_q  <= '0;
            len_q     <= '0;
            out_idx_q <= '0;
            tuser_q   <= '0;
            tvalid_q  <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            len_q     <= len_d;
            out_idx_q <= out_idx_d;
            tuser_q   <= tuser_d;
            tvalid_q  <= tvalid_d;
            drop_q    <= drop_d;
        end
    end

    // RAM read register is the output data stage; gate it so reset/idle shows zero.
    assign m_axis_tdata_o  = tvalid_q ? ram_rdata : '0;
    assign m_axis_tvalid_o = tvalid_q;
    assign m_axis_tlast_o  = tvalid_q && out_last;
    assign m_axis_tuser_o  = tuser_q;
    assign s_axis_tready_o = s_ready;
    assign drop_o          = drop_q;
    assign busy_o          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_udp_tx_frame_buffer.sv
// Directed bench for udp_tx_frame_buffer: frames in, replayed frames checked.
module tb_udp_tx_frame_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  s_data;
    logic        s_valid, s_last, s_ready;
    logic [7:0]  m_data;
    logic        m_valid, m_last, m_ready;
    logic [11:0] m_user;
    logic        drop, busy;

    udp_tx_frame_buffer #(
        .DEPTH   (2048),
        .MAX_LEN (1472),
        .LEN_W   (12)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .s_axis_tdata_i  (s_data),
        .s_axis_tvalid_i (s_valid),
        .s_axis_tlast_i  (s_last),
        .s_axis_tready_o (s_ready),
        .m_axis_tdata_o  (m_data),
        .m_axis_tvalid_o (m_valid),
        .m_axis_tlast_o  (m_last),
        .m_axis_tuser_o  (m_user),
        .m_axis_tready_i (m_ready),
        .drop_o          (drop),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int rdy_mode = 0;
    bit busy_track = 0;

    logic [7:0]  tx_q[$];
    logic [7:0]  rx_data[$];
    logic [11:0] rx_user[$];
    logic        rx_last[$];

    int rx_frames = 0, drop_cnt = 0, stall_err = 0, busy_err = 0;
    int in_last_cyc = 0, first_valid_cyc = 0;
    bit in_flight = 0, after_pending = 0, prev_valid = 0, held = 0;
    logic [7:0]  held_data;
    logic        held_last;
    logic [11:0] held_user;
    logic        after_ready, after_valid, after_busy;
    logic [11:0] after_user;

    int base, fr, dbase;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = (rdy_mode == 0) ? 1'b1 : ~m_ready;
        end
    end

    always @(negedge clk) begin
        if (drop) drop_cnt++;
        if (s_valid && s_ready && s_last) in_last_cyc = cyc;
        if (m_valid && !prev_valid) first_valid_cyc = cyc;
        if (after_pending) begin
            after_ready   = s_ready;
            after_valid   = m_valid;
            after_user    = m_user;
            after_busy    = busy;
            after_pending = 0;
        end
        if (m_valid && held &&
            (m_data !== held_data || m_last !== held_last || m_user !== held_user))
            stall_err++;
        if (busy_track && in_flight && !busy) busy_err++;
        if (busy_track && s_valid && s_ready) in_flight = 1;
        if (m_valid && m_ready) begin
            rx_data.push_back(m_data);
            rx_user.push_back(m_user);
            rx_last.push_back(m_last);
            if (m_last) begin
                rx_frames++;
                in_flight     = 0;
                after_pending = 1;
            end
        end
        held       = m_valid && !m_ready;
        held_data  = m_data;
        held_last  = m_last;
        held_user  = m_user;
        prev_valid = m_valid;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    task automatic send_frame(input string tag, input bit gaps);
        bit acc;
        int budget;
        for (int i = 0; i < tx_q.size(); i++) begin
            if (gaps) begin
                while ($urandom_range(1, 0) == 0) begin
                    s_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            s_data  = tx_q[i];
            s_last  = (i == tx_q.size() - 1);
            s_valid = 1'b1;
            budget  = 0;
            acc     = 0;
            while (!acc && budget < 50) begin
                @(negedge clk);
                acc = s_ready;
                @(posedge clk);
                #1;
                budget++;
            end
            if (!acc) begin
                check({tag, "_accept_timeout"}, 0, 1);
                break;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int target, input int budget);
        int n = 0;
        while (rx_frames < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        check({tag, "_frame_done"}, rx_frames, target);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic verify_frame(input string tag, input int b);
        int n = tx_q.size();
        int derr = 0, uerr = 0, lerr = 0;
        logic [11:0] exp_user = 12'(n);
        check({tag, "_count"}, rx_data.size() - b, n);
        for (int i = 0; i < n && b + i < rx_data.size(); i++) begin
            if (rx_data[b + i] !== tx_q[i]) derr++;
            if (rx_user[b + i] !== exp_user) uerr++;
            if (rx_last[b + i] !== (i == n - 1)) lerr++;
        end
        check({tag, "_data_err"}, derr, 0);
        check({tag, "_tuser_err"}, uerr, 0);
        check({tag, "_tlast_err"}, lerr, 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_s_tready", s_ready, 1);
        check("rst_m_tvalid", m_valid, 0);
        check("rst_m_tlast", m_last, 0);
        check("rst_m_tuser", m_user, 0);
        check("rst_m_tdata", m_data, 0);
        check("rst_drop", drop, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 4-byte frame, sink always ready
        tx_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        base = rx_data.size();
        fr   = rx_frames;
        send_frame("t1", 0);
        wait_out("t1", fr + 1, 200);
        verify_frame("t1", base);
        check("t1_latency", first_valid_cyc - in_last_cyc, 2);

        // single-byte frame
        tx_q = '{8'hA5};
        base = rx_data.size();
        fr   = rx_frames;
        send_frame("t2", 0);
        wait_out("t2", fr + 1, 200);
        verify_frame("t2", base);
        check("t2_tready_after", after_ready, 1);
        check("t2_tvalid_after", after_valid, 0);
        check("t2_tuser_after", after_user, 0);

        // maximum-length frame, sink toggling ready
        tx_q.delete();
        for (int i = 0; i < 1472; i++) tx_q.push_back(8'(i));
        base     = rx_data.size();
        fr       = rx_frames;
        rdy_mode = 1;
        send_frame("t3", 0);
        wait_out("t3", fr + 1, 5000);
        rdy_mode = 0;
        verify_frame("t3", base);
        check("t3_stall_stable_err", stall_err, 0);

        // oversize frame dropped, followed by a short frame
        tx_q.delete();
        for (int i = 0; i < 1473; i++) tx_q.push_back(8'(i * 3));
        base  = rx_data.size();
        fr    = rx_frames;
        dbase = drop_cnt;
        send_frame("t4a", 0);
        repeat (10) @(posedge clk);
        #1;
        check("t4_no_output", rx_data.size() - base, 0);
        check("t4_drop_pulses", drop_cnt - dbase, 1);
        tx_q = '{8'h01, 8'h02, 8'h03};
        send_frame("t4b", 0);
        wait_out("t4", fr + 1, 200);
        verify_frame("t4", base);
        check("t4_drop_total", drop_cnt - dbase, 1);

        // reset in the middle of draining a 20-byte frame
        tx_q.delete();
        for (int i = 0; i < 20; i++) tx_q.push_back(8'(8'h80 + i));
        base = rx_data.size();
        send_frame("t5a", 0);
        for (int n = 0; n < 200 && rx_data.size() - base < 5; n++) @(negedge clk);
        check("t5_five_out", rx_data.size() - base, 5);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_tvalid", m_valid, 0);
        check("t5_rst_tdata", m_data, 0);
        check("t5_rst_tuser", m_user, 0);
        check("t5_rst_tlast", m_last, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_tready", s_ready, 1);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tx_q = '{8'hC1, 8'hC2};
        base = rx_data.size();
        fr   = rx_frames;
        send_frame("t5b", 0);
        wait_out("t5", fr + 1, 200);
        verify_frame("t5", base);

        // 100-byte frame with random input gaps; busy tracked through the frame
        tx_q.delete();
        for (int i = 0; i < 100; i++) tx_q.push_back(8'(i * 7 + 3));
        base       = rx_data.size();
        fr         = rx_frames;
        busy_track = 1;
        send_frame("t6", 1);
        wait_out("t6", fr + 1, 500);
        busy_track = 0;
        verify_frame("t6", base);
        check("t6_busy_gap_err", busy_err, 0);
        check("t6_busy_after", after_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
